// File: rtl/y_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : y_serial_adder
// Brief    : Multi-cycle add/subtract, SLICE bits per clock with a rippled carry.
// Revision : 1.0
// ============================================================================
module y_serial_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] part_d;
    logic [WIDTH-1:0] z_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [SLICE-1:0] sa_w;
    logic [SLICE-1:0] sb_w;
    logic [SLICE:0]   sum_w;
    logic             ovf_w;

    always_comb begin
        sa_w = '0;
        sb_w = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                sa_w = a_q[i*SLICE +: SLICE];
                sb_w = b_q[i*SLICE +: SLICE];
            end
        end
    end

    assign sum_w = {1'b0, sa_w} + {1'b0, sb_w} + {{SLICE{1'b0}}, carry_q};
    // Carry into the top bit is recovered from that bit's sum and operands.
    assign ovf_w = sum_w[SLICE] ^ (sa_w[SLICE-1] ^ sb_w[SLICE-1] ^ sum_w[SLICE-1]);

    always_comb begin
        part_d = part_q;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                part_d[i*SLICE +: SLICE] = sum_w[SLICE-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            part_q  <= '0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    carry_q <= sum_w[SLICE];
                    part_q  <= part_d;
                    k_q     <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        z_q     <= part_d;
                        cout_q  <= sum_w[SLICE];
                        ovf_q   <= ovf_w;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub | cin;
                        k_q     <= '0;
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_y_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_serial_adder
// Brief    : Scoreboard bench for y_serial_adder (SLICE=8 and SLICE=32 instances).
// Revision : 1.0
// ============================================================================
module tb_y_serial_adder;

    typedef struct {
        logic [31:0] z;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] z;
        logic        c;
        logic        o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy1, done1, cout1, ovf1;
    logic        busy2, done2, cout2, ovf2;
    logic [31:0] z1, z2;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_done1 = 0;
    int   n_done2 = 0;
    int   done_cyc = 0;
    int   prev_done_cyc = 0;
    int   cap_cyc = 0;

    y_serial_adder #(.WIDTH(32), .SLICE(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .z(z1), .cout(cout1), .ovf(ovf1)
    );

    y_serial_adder #(.WIDTH(32), .SLICE(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy2), .done(done2), .z(z2), .cout(cout2), .ovf(ovf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (done1) begin
            exp_t e;
            prev_done_cyc = done_cyc;
            done_cyc      = cyc;
            n_done1++;
            chk("busy_done_excl8", {31'b0, busy1}, 32'd0);
            if (q1.size() == 0) begin
                chk("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("z8", z1, e.z);
                chk("cout8", {31'b0, cout1}, {31'b0, e.c});
                chk("ovf8", {31'b0, ovf1}, {31'b0, e.o});
            end
        end
        if (done2) begin
            exp_t e;
            n_done2++;
            chk("busy_done_excl32", {31'b0, busy2}, 32'd0);
            if (q2.size() == 0) begin
                chk("unexpected_done32", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("z32", z2, e.z);
                chk("cout32", {31'b0, cout2}, {31'b0, e.c});
                chk("ovf32", {31'b0, ovf2}, {31'b0, e.o});
            end
        end
    end

    task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic tc);
        a   = ta;
        b   = tb;
        sub = ts;
        cin = tc;
    endtask

    task automatic wait_dones(input int base, input int need, input string name);
        for (int n = 0; n < 40 && n_done1 < base + need; n++) begin
            @(posedge clk);
            #1;
        end
        chk(name, {31'b0, (n_done1 >= base + need)}, 32'd1);
    endtask

    task automatic run_op8(input vec_t v);
        int t;
        t = n_done1;
        drive(v.a, v.b, v.sub, v.cin);
        q1.push_back('{z: v.z, c: v.c, o: v.o});
        start1 = 1'b1;
        @(posedge clk);
        #1;
        cap_cyc = cyc;
        start1  = 1'b0;
        wait_dones(t, 1, "done_timeout8");
        chk("latency8", done_cyc - cap_cyc, 32'd4);
    endtask

    task automatic run_op32(input vec_t v);
        drive(v.a, v.b, v.sub, v.cin);
        q2.push_back('{z: v.z, c: v.c, o: v.o});
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        chk("busy32_run", {31'b0, busy2}, 32'd1);
        chk("done32_early", {31'b0, done2}, 32'd0);
        @(posedge clk);
        #1;
        chk("done32_latency", {31'b0, done2}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8] = '{
        '{a: 32'hFFFFFFFF, b: 32'h00000000, sub: 1'b0, cin: 1'b1, z: 32'h00000000, c: 1'b1, o: 1'b0},
        '{a: 32'h7FFFFFFF, b: 32'h00000001, sub: 1'b0, cin: 1'b0, z: 32'h80000000, c: 1'b0, o: 1'b1},
        '{a: 32'h00000005, b: 32'h00000007, sub: 1'b1, cin: 1'b1, z: 32'hFFFFFFFE, c: 1'b0, o: 1'b0},
        '{a: 32'h00000007, b: 32'h00000005, sub: 1'b1, cin: 1'b0, z: 32'h00000002, c: 1'b1, o: 1'b0},
        '{a: 32'h80000000, b: 32'h00000001, sub: 1'b1, cin: 1'b0, z: 32'h7FFFFFFF, c: 1'b1, o: 1'b1},
        '{a: 32'h12345678, b: 32'h11111111, sub: 1'b0, cin: 1'b1, z: 32'h2345678A, c: 1'b0, o: 1'b0},
        '{a: 32'h80000000, b: 32'h80000000, sub: 1'b0, cin: 1'b0, z: 32'h00000000, c: 1'b1, o: 1'b1},
        '{a: 32'h00000010, b: 32'h00000010, sub: 1'b1, cin: 1'b1, z: 32'h00000000, c: 1'b1, o: 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog actual=%0d required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_done", {31'b0, done1}, 32'd0);
        chk("rst_z", z1, 32'd0);
        chk("rst_cout", {31'b0, cout1}, 32'd0);
        chk("rst_ovf", {31'b0, ovf1}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_op8(vecs[i]);

        // Result must hold through idle and through the next RUN.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_idle_z", z1, 32'h00000000);
        chk("hold_idle_cout", {31'b0, cout1}, 32'd1);

        // start and operand changes during RUN are ignored.
        t = n_done1;
        drive(32'h00000001, 32'h00000002, 1'b0, 1'b0);
        q1.push_back('{z: 32'h00000003, c: 1'b0, o: 1'b0});
        start1 = 1'b1;
        @(posedge clk);
        #1;
        drive(32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("hold_run_z", z1, 32'h00000000);
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_dones(t, 1, "done_timeout_ign");

        // start held high for 10 cycles with operands changing every cycle.
        t = n_done1;
        q1.push_back('{z: 32'h00000010, c: 1'b0, o: 1'b0});
        q1.push_back('{z: 32'h0505051A, c: 1'b0, o: 1'b0});
        for (int i = 0; i < 10; i++) begin
            drive(32'h01010101 * i, 32'h10 + i, 1'b0, 1'b0);
            start1 = 1'b1;
            @(posedge clk);
            #1;
        end
        start1 = 1'b0;
        wait_dones(t, 2, "done_timeout_b2b");
        chk("b2b_period", done_cyc - prev_done_cyc, 32'd5);

        // Abort after 2 RUN edges: outputs clear immediately and no done follows.
        t = n_done1;
        drive(32'h00000011, 32'h00000022, 1'b0, 1'b0);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy1}, 32'd0);
        chk("abort_done", {31'b0, done1}, 32'd0);
        chk("abort_z", z1, 32'd0);
        chk("abort_cout", {31'b0, cout1}, 32'd0);
        chk("abort_ovf", {31'b0, ovf1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        chk("abort_no_done", n_done1 - t, 32'd0);
        @(negedge clk);
        run_op8('{a: 32'h00000003, b: 32'h00000004, sub: 1'b0, cin: 1'b0, z: 32'h00000007, c: 1'b0, o: 1'b0});

        // Single-slice instance completes one edge after capture.
        run_op32('{a: 32'h12345678, b: 32'h11111111, sub: 1'b0, cin: 1'b0, z: 32'h23456789, c: 1'b0, o: 1'b0});
        run_op32('{a: 32'hFFFFFFFF, b: 32'h00000000, sub: 1'b0, cin: 1'b1, z: 32'h00000000, c: 1'b1, o: 1'b0});
        run_op32('{a: 32'h00000005, b: 32'h00000007, sub: 1'b1, cin: 1'b1, z: 32'hFFFFFFFE, c: 1'b0, o: 1'b0});
        run_op32('{a: 32'h7FFFFFFF, b: 32'h00000001, sub: 1'b0, cin: 1'b0, z: 32'h80000000, c: 1'b0, o: 1'b1});

        repeat (3) @(posedge clk);
        chk("q8_drained", q1.size(), 32'd0);
        chk("q32_drained", q2.size(), 32'd0);
        chk("dones32", n_done2, 32'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/y_serial_adder.md
Y_SERIAL_ADDER -- requirements
Module: y_serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The module SHALL have parameter SLICE, default 8, the bits added per clock; WIDTH SHALL be an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: request an operation; sampled on clk.
REQ-007 The module SHALL have port sub, input, 1 bit: 0 selects a+b+cin, 1 selects a-b; sampled with start.
REQ-008 The module SHALL have ports a and b, input, WIDTH bits each: operands; sampled with start.
REQ-009 The module SHALL have port cin, input, 1 bit: carry-in; sampled with start; ignored when sub=1.
REQ-010 The module SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse marking that the result is valid.
REQ-012 The module SHALL have port z, output, WIDTH bits: sum or difference.
REQ-013 The module SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-014 The module SHALL have port ovf, output, 1 bit: two's-complement overflow.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b XOR {WIDTH{sub}}, and carry = sub ? 1 : cin.
REQ-017 That same capturing edge SHALL clear the slice counter and enter RUN with busy=1.
REQ-018 In RUN, each rising edge SHALL add slice k (bits k*SLICE+SLICE-1..k*SLICE) of both captured operands plus the stored carry.
REQ-019 Each RUN edge SHALL store that slice's sum, store its carry-out as the next carry, and increment k.
REQ-020 The edge that processes slice N-1 SHALL load z with the full result and cout with the final carry.
REQ-021 On that same edge, ovf SHALL be loaded with (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-022 On that same edge, the FSM SHALL enter DONE, with done=1 and busy=0.
REQ-023 Latency SHALL be exactly N rising edges from the start-capture edge to the edge that raises done.
REQ-024 DONE SHALL last exactly one cycle and SHALL then return to IDLE, unless start=1 in DONE, in which case it re-enters RUN (back-to-back).
REQ-025 start asserted while in RUN SHALL be ignored, with no effect on state, operands or outputs.
REQ-026 z, cout and ovf SHALL change only on the completion edge, and SHALL hold their value through IDLE and through subsequent RUN until the next completion.
REQ-027 All arithmetic SHALL be modulo 2^WIDTH; slice sums SHALL be SLICE+1 bits, with the MSB being the slice carry.
REQ-028 When SLICE = WIDTH (N=1), the module SHALL complete in one RUN edge with identical semantics.
REQ-029 busy and done SHALL never both be 1.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, force the FSM to IDLE.
REQ-031 rst=1 SHALL immediately force busy=0, done=0, z=0, cout=0, ovf=0, the counter to 0 and the stored carry to 0.
REQ-032 rst asserted during RUN SHALL abort the operation with no done pulse, and start SHALL be honoured on the first edge after rst deasserts.

Verification
REQ-033 (WIDTH=32, SLICE=8) a=0xFFFFFFFF, b=0, cin=1, sub=0 -> after 4 edges z=0x00000000, cout=1, ovf=0, done high for 1 cycle.
REQ-034 a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> z=0x80000000, cout=0, ovf=1.
REQ-035 a=5, b=7, sub=1, cin=1 -> z=0xFFFFFFFE, cout=0, ovf=0; then a=7, b=5, sub=1 -> z=0x00000002, cout=1.
REQ-036 start held high for 10 cycles with changing operands -> only the first operands and the ones present in each DONE cycle are processed; done pulses every 5 cycles.
REQ-037 rst pulsed after 2 RUN edges -> busy, done, z, cout, ovf all 0 immediately; no done pulse follows.
REQ-038 With SLICE=32: a=0x12345678, b=0x11111111, cin=0 -> z=0x23456789 and done 1 edge after start.
